// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load bus of the loadable instruction memory.
// master = PC/fetch logic plus boot loader, slave = the memory block.
interface instr_mem_loadable_if #(
    parameter int INST_W = 9,
    parameter int PC_W   = 16
);
    logic [PC_W-1:0]   pc;
    logic              fetch_en;
    logic              stall;
    logic [INST_W-1:0] instruction;
    logic              inst_valid;

    logic              ld_start;
    logic [PC_W-1:0]   ld_base;
    logic              ld_valid;
    logic [INST_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic [PC_W-1:0]   ld_count;
    logic              ld_overflow;
    logic              busy;

    modport master (
        output pc, fetch_en, stall, ld_start, ld_base, ld_valid, ld_data, ld_last,
        input  instruction, inst_valid, ld_ready, ld_done, ld_count, ld_overflow, busy
    );

    modport slave (
        input  pc, fetch_en, stall, ld_start, ld_base, ld_valid, ld_data, ld_last,
        output instruction, inst_valid, ld_ready, ld_done, ld_count, ld_overflow, busy
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: registered fetch port, handshaked sequential
// program load, and a written-bitmap so unloaded words fetch HALT_WORD.
module instr_mem_loadable #(
    parameter int                INST_W    = 9,
    parameter int                PC_W      = 16,
    parameter int                ADDR_W    = 8,
    parameter logic [INST_W-1:0] HALT_WORD = 9'h1A0
) (
    input logic                  clk,
    input logic                  rst,
    instr_mem_loadable_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [PC_W:0] DEPTH_CNT = (PC_W + 1)'(DEPTH);

    typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [DEPTH-1:0]  written;
    logic [INST_W-1:0] mem [DEPTH];

    logic              accept;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_hit;

    assign accept = bus.ld_valid && bus.ld_ready;
    assign rd_idx = bus.pc[ADDR_W-1:0];
    assign rd_hit = ((bus.pc >> ADDR_W) == '0) && written[rd_idx];

    // Storage is deliberately not reset; the bitmap alone decides validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            wptr            <= '0;
            written         <= '0;
            bus.ld_ready    <= 1'b0;
            bus.ld_done     <= 1'b0;
            bus.ld_count    <= '0;
            bus.ld_overflow <= 1'b0;
            bus.busy        <= 1'b0;
            bus.instruction <= HALT_WORD;
            bus.inst_valid  <= 1'b0;
        end else begin
            bus.ld_done <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.ld_start) begin
                        state           <= LOAD;
                        wptr            <= bus.ld_base[ADDR_W-1:0];
                        bus.ld_count    <= '0;
                        bus.ld_overflow <= 1'b0;
                        bus.ld_ready    <= 1'b1;
                        bus.busy        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        written[wptr] <= 1'b1;
                        wptr          <= wptr + 1'b1;
                        if (bus.ld_count != '1) begin
                            bus.ld_count <= bus.ld_count + 1'b1;
                        end
                        // Pre-increment count >= DEPTH means this is word DEPTH+1 or later.
                        if ({1'b0, bus.ld_count} >= DEPTH_CNT) begin
                            bus.ld_overflow <= 1'b1;
                        end
                        if (bus.ld_last) begin
                            state        <= DONE;
                            bus.ld_ready <= 1'b0;
                            bus.ld_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= RUN;
                    bus.busy <= 1'b0;
                end
                default: state <= RUN;
            endcase

            if (!bus.stall) begin
                if (state == RUN && bus.fetch_en) begin
                    bus.inst_valid  <= 1'b1;
                    bus.instruction <= rd_hit ? mem[rd_idx] : HALT_WORD;
                end else begin
                    bus.inst_valid  <= 1'b0;
                    bus.instruction <= HALT_WORD;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: a default-size instance and a
// 4-deep instance for wrap/overflow, fetches checked through a scoreboard.
module tb_instr_mem_loadable;
    localparam int         INST_W = 9;
    localparam int         PC_W   = 16;
    localparam logic [8:0] HALT   = 9'h1A0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_loadable_if #(.INST_W(INST_W), .PC_W(PC_W)) bus ();
    instr_mem_loadable_if #(.INST_W(INST_W), .PC_W(PC_W)) wbus ();

    instr_mem_loadable #(
        .INST_W(INST_W), .PC_W(PC_W), .ADDR_W(8), .HALT_WORD(HALT)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    instr_mem_loadable #(
        .INST_W(INST_W), .PC_W(PC_W), .ADDR_W(2), .HALT_WORD(HALT)
    ) dut_wrap (.clk(clk), .rst(rst), .bus(wbus));

    int total  = 0;
    int passed = 0;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } exp_t;
    exp_t sb[$];

    logic [8:0] model_mem [int];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] model_read(input int a);
        if (a > 255 || !model_mem.exists(a)) return HALT;
        return model_mem[a];
    endfunction

    task automatic fetch_main(input logic [15:0] a);
        exp_t e;
        e.tag = $sformatf("fetch_%0h", a);
        e.exp = model_read(int'(a));
        bus.pc       = a;
        bus.fetch_en = 1'b1;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        check({e.tag, "_insn"}, 32'(bus.instruction), 32'(e.exp));
        check({e.tag, "_vld"}, 32'(bus.inst_valid), 32'd1);
        bus.fetch_en = 1'b0;
    endtask

    task automatic fetch_wrap(input logic [15:0] a, input logic [8:0] exp);
        exp_t e;
        e.tag = $sformatf("wfetch_%0h", a);
        e.exp = exp;
        wbus.pc       = a;
        wbus.fetch_en = 1'b1;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        check({e.tag, "_insn"}, 32'(wbus.instruction), 32'(e.exp));
        check({e.tag, "_vld"}, 32'(wbus.inst_valid), 32'd1);
        wbus.fetch_en = 1'b0;
    endtask

    task automatic send_main(input logic [8:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic send_wrap(input logic [8:0] d, input logic last);
        wbus.ld_valid = 1'b1;
        wbus.ld_data  = d;
        wbus.ld_last  = last;
        tick();
        wbus.ld_valid = 1'b0;
        wbus.ld_last  = 1'b0;
    endtask

    initial begin
        logic [8:0] wrap_words [5];
        wrap_words = '{9'h00A, 9'h00B, 9'h00C, 9'h00D, 9'h00E};

        rst = 1'b1;
        bus.pc = '0;  bus.fetch_en = 1'b0;  bus.stall = 1'b0;  bus.ld_start = 1'b0;
        bus.ld_base = '0;  bus.ld_valid = 1'b0;  bus.ld_data = '0;  bus.ld_last = 1'b0;
        wbus.pc = '0; wbus.fetch_en = 1'b0; wbus.stall = 1'b0; wbus.ld_start = 1'b0;
        wbus.ld_base = '0; wbus.ld_valid = 1'b0; wbus.ld_data = '0; wbus.ld_last = 1'b0;
        tick();
        tick();
        check("rst_insn", 32'(bus.instruction), 32'(HALT));
        check("rst_vld", 32'(bus.inst_valid), 32'd0);
        check("rst_ready", 32'(bus.ld_ready), 32'd0);
        check("rst_done", 32'(bus.ld_done), 32'd0);
        check("rst_count", 32'(bus.ld_count), 32'd0);
        check("rst_ovf", 32'(bus.ld_overflow), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Empty memory fetches HALT everywhere.
        for (int i = 0; i < 4; i++) fetch_main(16'(i));

        // Load 3 words at base 1 with a 2-cycle gap and an ignored restart.
        bus.ld_base  = 16'd1;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        check("ld_ready_up", 32'(bus.ld_ready), 32'd1);
        check("ld_busy_up", 32'(bus.busy), 32'd1);
        bus.fetch_en = 1'b1;
        bus.pc       = 16'd1;
        send_main(9'h0C1, 1'b0);
        bus.fetch_en = 1'b0;
        check("load_no_fetch_vld", 32'(bus.inst_valid), 32'd0);
        check("load_no_fetch_insn", 32'(bus.instruction), 32'(HALT));
        check("ld_count_1", 32'(bus.ld_count), 32'd1);
        bus.ld_start = 1'b1;
        bus.ld_base  = 16'h0050;
        bus.ld_last  = 1'b1;
        bus.ld_data  = 9'h1FF;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_last  = 1'b0;
        check("gap1_count", 32'(bus.ld_count), 32'd1);
        check("gap1_ready", 32'(bus.ld_ready), 32'd1);
        tick();
        check("gap2_count", 32'(bus.ld_count), 32'd1);
        send_main(9'h120, 1'b0);
        send_main(9'h191, 1'b1);
        check("done_pulse", 32'(bus.ld_done), 32'd1);
        check("done_ready", 32'(bus.ld_ready), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("done_count", 32'(bus.ld_count), 32'd3);
        check("done_ovf", 32'(bus.ld_overflow), 32'd0);
        model_mem[1] = 9'h0C1;
        model_mem[2] = 9'h120;
        model_mem[3] = 9'h191;

        // Fetch during DONE is not serviced; RUN returns next cycle.
        bus.fetch_en = 1'b1;
        bus.pc       = 16'd1;
        tick();
        bus.fetch_en = 1'b0;
        check("done_fetch_vld", 32'(bus.inst_valid), 32'd0);
        check("run_done_low", 32'(bus.ld_done), 32'd0);
        check("run_busy_low", 32'(bus.busy), 32'd0);
        check("run_count_kept", 32'(bus.ld_count), 32'd3);

        fetch_main(16'd1);
        fetch_main(16'd2);
        fetch_main(16'd3);
        fetch_main(16'd4);
        fetch_main(16'h0050);
        fetch_main(16'h0100);
        fetch_main(16'h0101);

        // Stall holds outputs even with fetch_en low and pc moving.
        fetch_main(16'd2);
        bus.stall = 1'b1;
        foreach (wrap_words[i]) begin
            if (i < 3) begin
                bus.pc = 16'(i * 7);
                tick();
                check($sformatf("stall%0d_insn", i), 32'(bus.instruction), 32'h120);
                check($sformatf("stall%0d_vld", i), 32'(bus.inst_valid), 32'd1);
            end
        end
        bus.stall = 1'b0;
        fetch_main(16'd3);

        // Reset after 2 of 4 words aborts the load and clears the bitmap.
        bus.ld_base  = 16'h0010;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        send_main(9'h011, 1'b0);
        send_main(9'h022, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_mem.delete();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ready", 32'(bus.ld_ready), 32'd0);
        check("abort_count", 32'(bus.ld_count), 32'd0);
        fetch_main(16'h0010);
        fetch_main(16'h0011);
        fetch_main(16'd1);

        // 4-deep instance: 5 words from base 3 wrap and overwrite slot 3.
        wbus.ld_base  = 16'd3;
        wbus.ld_start = 1'b1;
        tick();
        wbus.ld_start = 1'b0;
        for (int i = 0; i < 4; i++) send_wrap(wrap_words[i], 1'b0);
        check("wrap4_ovf", 32'(wbus.ld_overflow), 32'd0);
        check("wrap4_count", 32'(wbus.ld_count), 32'd4);
        send_wrap(wrap_words[4], 1'b1);
        check("wrap5_ovf", 32'(wbus.ld_overflow), 32'd1);
        check("wrap5_count", 32'(wbus.ld_count), 32'd5);
        check("wrap5_done", 32'(wbus.ld_done), 32'd1);
        tick();
        fetch_wrap(16'd0, wrap_words[1]);
        fetch_wrap(16'd1, wrap_words[2]);
        fetch_wrap(16'd2, wrap_words[3]);
        fetch_wrap(16'd3, wrap_words[4]);
        fetch_wrap(16'd4, HALT);
        check("wrap_ovf_sticky", 32'(wbus.ld_overflow), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, loadable instruction memory for the pipelined CPU's fetch stage. It replaces a fixed, combinational program table with three things: a registered read port, a handshaked sequential program-load port, and per-word written tracking. Any unwritten or out-of-range location fetches the `halt` instruction. The block sits between the PC register and the IF/ID pipeline register, and the load port is driven by the boot/test harness.

## Interface
Parameters:
- `INST_W`, default 9: instruction width (5-bit opcode + 4-bit operand at default).
- `PC_W`, default 16: PC and load-address width.
- `ADDR_W`, default 8: memory index width; DEPTH = 2**ADDR_W (default 256).
- `HALT_WORD`, default 9'h1A0: word returned for unwritten or out-of-range fetches (opcode 5'b11010, operand 0).

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `pc`, input, PC_W: fetch address.
- `fetch_en`, input, 1: request a fetch this cycle.
- `stall`, input, 1: hold the fetch outputs.
- `instruction`, output, INST_W: registered fetched word.
- `inst_valid`, output, 1: `instruction` holds a real fetch result.
- `ld_start`, input, 1: begin a program load (accepted only in RUN).
- `ld_base`, input, PC_W: first load address; sampled on an accepted `ld_start`.
- `ld_valid`, input, 1: `ld_data` is offered.
- `ld_data`, input, INST_W: word to write.
- `ld_last`, input, 1: qualifies the final word of a load.
- `ld_ready`, output, 1: block accepts a load word.
- `ld_done`, output, 1: one-cycle pulse when a load completes.
- `ld_count`, output, PC_W: words accepted in the current or last load.
- `ld_overflow`, output, 1: sticky; the load wrapped past DEPTH words.
- `busy`, output, 1: state is not RUN.

## Operation
- Storage: DEPTH × INST_W array, plus a DEPTH-bit `written` bitmap. The bitmap resets to 0; the array itself is not reset.
- FSM states: RUN, LOAD, DONE.
  - RUN → LOAD on `ld_start`. Latches `wptr = ld_base[ADDR_W-1:0]`; clears `ld_count` and `ld_overflow`.
  - `ld_start` in LOAD or DONE is ignored.
  - LOAD: `ld_ready = 1`. A word is accepted on `ld_valid && ld_ready`. On acceptance:
    - `mem[wptr] <= ld_data` and `written[wptr] <= 1`.
    - `wptr` increments modulo DEPTH.
    - `ld_count` increments, saturating at 2**PC_W-1.
    - If the accepted word is word number DEPTH+1 or later, `ld_overflow` is set. Wrap-around overwrites earlier words.
  - An accepted word with `ld_last = 1` → DONE. `ld_last` without `ld_valid` has no effect.
  - DONE: `ld_done = 1` for exactly one cycle, then → RUN.
- Fetch rule, evaluated each cycle (priority order):
  1. `rst`
  2. `stall = 1`: `instruction` and `inst_valid` hold, in any state.
  3. state == RUN and `fetch_en = 1`: `inst_valid <= 1`. `instruction <=` `HALT_WORD` if `pc[PC_W-1:ADDR_W] != 0` or `!written[pc[ADDR_W-1:0]]`, else `mem[pc[ADDR_W-1:0]]`.
  4. Otherwise: `instruction <= HALT_WORD`, `inst_valid <= 0`.
- Reads never occur in LOAD, so there is no read/write collision.
- Reset values: state RUN; `instruction = HALT_WORD`; `inst_valid = 0`; `ld_ready = 0`; `ld_done = 0`; `ld_count = 0`; `ld_overflow = 0`; `busy = 0`; `written` all 0.
- Reset during LOAD aborts the load. The bitmap clears, so partially loaded words read as `HALT_WORD`.

## Timing
- Fetch latency is 1 cycle: `pc` sampled at edge N appears on `instruction` after edge N, with `inst_valid = 1`.
- Back-to-back fetches sustain one per cycle.
- `ld_ready` and `busy` are registered from the state:
  - `ld_ready` is high from the cycle after the accepted `ld_start` until the cycle the `ld_last` word is accepted (inclusive).
  - `busy` is 1 in LOAD and DONE.
- A word written at edge N is fetchable at edge N+2 at the earliest (DONE cycle, then RUN).
- Minimum load of 1 word: `ld_start` (cycle 0), data (cycle 1), `ld_done` (cycle 2), RUN (cycle 3).

## Test plan
- Reset then fetch: `fetch_en = 1`, pc = 0..3 → `instruction = 9'h1A0`, `inst_valid = 1` each cycle after the first edge.
- Load and run: `ld_base = 1`; load 9'h0C1, 9'h120, 9'h191, last. Then expect `ld_done` pulse and `ld_count = 3`. Fetch pc = 1, 2, 3, 4 → 9'h0C1, 9'h120, 9'h191, 9'h1A0.
- Handshake gaps: drop `ld_valid` for 2 cycles mid-load → no extra writes and `ld_count` unchanged. `ld_start` during LOAD is ignored, so the base is unchanged.
- Wrap/overflow, with ADDR_W = 2:
  - `ld_base = 3`, load 5 words A..E, last on E → `ld_overflow = 1`, `ld_count = 5`.
  - mem[3] = E, mem[0] = B, mem[1] = C, mem[2] = D.
- Out of range and stall:
  - pc = 16'h0100 at ADDR_W = 8 → `HALT_WORD`.
  - Assert `stall` 3 cycles while pc changes → `instruction` and `inst_valid` unchanged. Release → the new pc's word after 1 cycle.
- Reset mid-load: `rst` after 2 of 4 words → state RUN, `ld_ready = 0`, `busy = 0`, and fetching those 2 addresses returns `HALT_WORD`.
